// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: synchronised edge capture, mask, pending/in-service tracking and a REQ/SVC handshake.
// Optional preemption of a running handler by a higher-priority line is enabled by defining NESTED_INT_EN.
module interrupt_controller #(
  parameter int              N_IRQ     = 8,
  parameter int              ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'('h010),
  parameter int              VEC_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IRQ-1:0]  irq_i,
  input  logic              int_ack_i,
  input  logic              reti_i,
  input  logic              mask_we_i,
  input  logic [N_IRQ-1:0]  mask_data_i,
  output logic              int_req_o,
  output logic [ADDR_W-1:0] vector_o,
  output logic [N_IRQ-1:0]  mask_o,
  output logic [N_IRQ-1:0]  pending_o,
  output logic [N_IRQ-1:0]  in_svc_o
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t             r_state;
  logic [N_IRQ-1:0]   r_sync1;
  logic [N_IRQ-1:0]   r_sync2;
  logic [N_IRQ-1:0]   r_sync3;
  logic [N_IRQ-1:0]   r_pending;
  logic [N_IRQ-1:0]   r_inSvc;
  logic [N_IRQ-1:0]   r_mask;
  logic [IDX_W-1:0]   r_idx;
  logic [ADDR_W-1:0]  r_vector;
  logic               r_intReq;

  logic [N_IRQ-1:0]   w_rise;
  logic [N_IRQ-1:0]   w_eligible;
  logic               w_anyElig;
  logic [IDX_W-1:0]   w_winIdx;
  logic [ADDR_W-1:0]  w_winVec;
  logic [N_IRQ-1:0]   w_idxOneHot;
  logic [N_IRQ-1:0]   w_svcLowest;
  logic [N_IRQ-1:0]   w_pendClr;
  logic [N_IRQ-1:0]   w_svcSet;
  logic [N_IRQ-1:0]   w_svcClr;
  logic [N_IRQ-1:0]   w_inSvcNext;
`ifdef NESTED_INT_EN
  logic               w_preempt;
`endif

  // r_sync3 holds the previous synchronised level so a rising edge lasts exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_sync3;
  assign w_eligible  = r_pending & r_mask & ~r_inSvc;
  assign w_anyElig   = |w_eligible;
  assign w_idxOneHot = N_IRQ'(1) << r_idx;
  assign w_svcLowest = r_inSvc & (~r_inSvc + N_IRQ'(1));
  assign w_winVec    = VEC_BASE + (ADDR_W'(w_winIdx) << VEC_SHIFT);
`ifdef NESTED_INT_EN
  assign w_preempt   = |(w_eligible & (w_svcLowest - N_IRQ'(1)));
`endif

  always_comb begin
    w_winIdx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winIdx = IDX_W'(i);
    end
  end

  always_comb begin
    w_pendClr = '0;
    w_svcSet  = '0;
    w_svcClr  = '0;
    case (r_state)
      REQ: begin
        if (int_ack_i) begin
          w_pendClr = w_idxOneHot;
          w_svcSet  = w_idxOneHot;
        end
      end
      SVC: begin
        if (reti_i) w_svcClr = w_svcLowest;
      end
      default: ;
    endcase
  end

  assign w_inSvcNext = (r_inSvc & ~w_svcClr) | w_svcSet;

  // A fresh edge on the acknowledged line re-arms it, so set has priority over the ack clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_inSvc   <= '0;
      r_mask    <= '0;
      r_idx     <= '0;
      r_vector  <= VEC_BASE;
      r_intReq  <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_pendClr) | w_rise;
      r_inSvc   <= w_inSvcNext;
      if (mask_we_i) r_mask <= mask_data_i;
      case (r_state)
        IDLE: begin
          if (w_anyElig) begin
            r_state  <= REQ;
            r_idx    <= w_winIdx;
            r_vector <= w_winVec;
            r_intReq <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack_i) begin
            r_state  <= SVC;
            r_intReq <= 1'b0;
          end else if (!w_eligible[r_idx]) begin
            r_state  <= (|r_inSvc) ? SVC : IDLE;
            r_intReq <= 1'b0;
          end
        end
        SVC: begin
          if (reti_i) begin
            if (w_inSvcNext == '0) r_state <= IDLE;
          end
`ifdef NESTED_INT_EN
          else if (w_preempt) begin
            r_state  <= REQ;
            r_idx    <= w_winIdx;
            r_vector <= w_winVec;
            r_intReq <= 1'b1;
          end
`endif
        end
        default: begin
          r_state  <= IDLE;
          r_intReq <= 1'b0;
        end
      endcase
    end
  end

  assign int_req_o = r_intReq;
  assign vector_o  = r_vector;
  assign mask_o    = r_mask;
  assign pending_o = r_pending;
  assign in_svc_o  = r_inSvc;

endmodule
